// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle MIPS-subset core.
// Steps each instruction through fetch/decode/execute/memory/writeback states,
// drives the datapath selects and write enables, and stalls on mem_ready.
//
// Ports:
//   clk, rst_n      - clock (rising edge), asynchronous active-low reset
//   op              - opcode field instr[31:26]
//   zero            - ALU zero flag, qualifies the branch PC update
//   mem_ready       - memory access completes this cycle
//   ir_write, pc_en, mem_write, reg_write - datapath write enables
//   iord, reg_dst, mem_to_reg, alu_src_a, alu_src_b, pc_src - datapath selects
//   alu_op          - to ALU-function decoder (00 add, 01 sub, 10 funct)
//   illegal_op      - pulse in DECODE on an unsupported opcode
//   state_dbg       - current state encoding
module multicycle_controller (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       ir_write,
  output logic       pc_en,
  output logic       mem_write,
  output logic       reg_write,
  output logic       iord,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic [1:0] alu_op,
  output logic       illegal_op,
  output logic [3:0] state_dbg
);

  localparam int unsigned STATE_W = 4;
  localparam int unsigned OP_W    = 6;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BEQ      = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  state_t state_q;
  state_t state_d;

  // Raw decoded enables, before reset gating
  logic pc_write;
  logic branch;
  logic ir_write_raw;
  logic mem_write_raw;
  logic reg_write_raw;
  logic illegal_raw;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and Moore output decode (mem_ready/zero qualifiers only)
  always_comb begin
    state_d       = S_FETCH;
    pc_write      = 1'b0;
    branch        = 1'b0;
    ir_write_raw  = 1'b0;
    mem_write_raw = 1'b0;
    reg_write_raw = 1'b0;
    illegal_raw   = 1'b0;
    iord          = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    pc_src        = 2'b00;
    alu_op        = 2'b00;

    case (state_q)
      S_FETCH: begin
        alu_src_b    = 2'b01;
        ir_write_raw = mem_ready;
        pc_write     = mem_ready;
        state_d      = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BEQ;
          OP_ADDI:      state_d = S_ADDIEXEC;
          OP_J:         state_d = S_JUMP;
          default: begin
            state_d     = S_FETCH;
            illegal_raw = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        // op is held by the instruction register; anything but sw is a load here
        state_d   = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        iord    = 1'b1;
        state_d = mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        mem_to_reg    = 1'b1;
        reg_write_raw = 1'b1;
        state_d       = S_FETCH;
      end
      S_MEMWR: begin
        iord          = 1'b1;
        mem_write_raw = mem_ready;
        state_d       = mem_ready ? S_FETCH : S_MEMWR;
      end
      S_EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_dst       = 1'b1;
        reg_write_raw = 1'b1;
        state_d       = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_src    = 2'b01;
        branch    = 1'b1;
        state_d   = S_FETCH;
      end
      S_ADDIEXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write_raw = 1'b1;
        state_d       = S_FETCH;
      end
      S_JUMP: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
        state_d  = S_FETCH;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // Enables are gated by rst_n so none can pulse while reset is held,
  // even though FETCH would otherwise assert them when mem_ready is high.
  assign ir_write   = rst_n & ir_write_raw;
  assign pc_en      = rst_n & (pc_write | (branch & zero));
  assign mem_write  = rst_n & mem_write_raw;
  assign reg_write  = rst_n & reg_write_raw;
  assign illegal_op = rst_n & illegal_raw;
  assign state_dbg  = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed self-checking bench for multicycle_controller.
module tb_multicycle_controller;

  logic       clk;
  logic       rst_n;
  logic [5:0] op;
  logic       zero;
  logic       mem_ready;
  logic       ir_write;
  logic       pc_en;
  logic       mem_write;
  logic       reg_write;
  logic       iord;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] pc_src;
  logic [1:0] alu_op;
  logic       illegal_op;
  logic [3:0] state_dbg;

  int checks   = 0;
  int failures = 0;

  multicycle_controller dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op         (op),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .ir_write   (ir_write),
    .pc_en      (pc_en),
    .mem_write  (mem_write),
    .reg_write  (reg_write),
    .iord       (iord),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .pc_src     (pc_src),
    .alu_op     (alu_op),
    .illegal_op (illegal_op),
    .state_dbg  (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are changed and outputs sampled after the edge
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; op = 6'h00; zero = 1'b0; mem_ready = 1'b1;
    #2;
    chk("rst_state", 8'(state_dbg), 8'd0);
    chk("rst_pc_en", 8'(pc_en), 8'd0);
    chk("rst_ir_write", 8'(ir_write), 8'd0);
    chk("rst_alu_src_b", 8'(alu_src_b), 8'd1);
    tick; tick;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    // Mid-EXECUTE reset
    chk("fetch_pc_en", 8'(pc_en), 8'd1);
    chk("fetch_ir_write", 8'(ir_write), 8'd1);
    tick; op = 6'b000000; #1;
    chk("r0_decode", 8'(state_dbg), 8'd1);
    tick;
    chk("r0_execute", 8'(state_dbg), 8'd6);
    rst_n = 1'b0; #1;
    chk("async_rst_state", 8'(state_dbg), 8'd0);
    chk("async_rst_reg_write", 8'(reg_write), 8'd0);
    chk("async_rst_pc_en", 8'(pc_en), 8'd0);
    tick;
    chk("held_rst_state", 8'(state_dbg), 8'd0);
    chk("held_rst_reg_write", 8'(reg_write), 8'd0);
    @(negedge clk);
    rst_n = 1'b1; #1;
    chk("post_rst_pc_en", 8'(pc_en), 8'd1);
    tick;
    chk("post_rst_decode", 8'(state_dbg), 8'd1);
    op = 6'b100011; #1;
    // lw: 1,2,3,4,0
    chk("lw_s1_alu_op", 8'(alu_op), 8'd0);
    chk("lw_s1_srcb", 8'(alu_src_b), 8'd3);
    tick;
    chk("lw_s2", 8'(state_dbg), 8'd2);
    chk("lw_s2_srca", 8'(alu_src_a), 8'd1);
    chk("lw_s2_srcb", 8'(alu_src_b), 8'd2);
    chk("lw_s2_alu_op", 8'(alu_op), 8'd0);
    tick;
    chk("lw_s3", 8'(state_dbg), 8'd3);
    chk("lw_s3_iord", 8'(iord), 8'd1);
    chk("lw_s3_alu_op", 8'(alu_op), 8'd0);
    tick;
    chk("lw_s4", 8'(state_dbg), 8'd4);
    chk("lw_s4_reg_write", 8'(reg_write), 8'd1);
    chk("lw_s4_mem_to_reg", 8'(mem_to_reg), 8'd1);
    chk("lw_s4_reg_dst", 8'(reg_dst), 8'd0);
    chk("lw_s4_alu_op", 8'(alu_op), 8'd0);
    tick;
    chk("lw_s0", 8'(state_dbg), 8'd0);
    // FETCH stall with mem_ready low
    mem_ready = 1'b0; #1;
    chk("fetch_stall_pc_en", 8'(pc_en), 8'd0);
    chk("fetch_stall_ir_write", 8'(ir_write), 8'd0);
    tick;
    chk("fetch_stall_state", 8'(state_dbg), 8'd0);
    mem_ready = 1'b1;
    // sw with two wait cycles in MEMWR
    tick; op = 6'b101011;
    tick;
    chk("sw_s2", 8'(state_dbg), 8'd2);
    tick; mem_ready = 1'b0; #1;
    chk("sw_s5_a", 8'(state_dbg), 8'd5);
    chk("sw_s5_a_mw", 8'(mem_write), 8'd0);
    chk("sw_s5_a_iord", 8'(iord), 8'd1);
    tick;
    chk("sw_s5_b", 8'(state_dbg), 8'd5);
    chk("sw_s5_b_mw", 8'(mem_write), 8'd0);
    chk("sw_s5_b_iord", 8'(iord), 8'd1);
    mem_ready = 1'b1; #1;
    chk("sw_s5_c", 8'(state_dbg), 8'd5);
    chk("sw_s5_c_mw", 8'(mem_write), 8'd1);
    chk("sw_s5_c_iord", 8'(iord), 8'd1);
    tick;
    chk("sw_s0", 8'(state_dbg), 8'd0);
    chk("sw_s0_mw", 8'(mem_write), 8'd0);
    // R-type
    tick; op = 6'b000000;
    tick;
    chk("r_s6", 8'(state_dbg), 8'd6);
    chk("r_s6_alu_op", 8'(alu_op), 8'd2);
    chk("r_s6_srca", 8'(alu_src_a), 8'd1);
    tick;
    chk("r_s7", 8'(state_dbg), 8'd7);
    chk("r_s7_reg_dst", 8'(reg_dst), 8'd1);
    chk("r_s7_reg_write", 8'(reg_write), 8'd1);
    tick;
    chk("r_s0", 8'(state_dbg), 8'd0);
    // beq taken then not taken
    tick; op = 6'b000100; zero = 1'b1;
    tick; #1;
    chk("beq1_s8", 8'(state_dbg), 8'd8);
    chk("beq1_pc_en", 8'(pc_en), 8'd1);
    chk("beq1_pc_src", 8'(pc_src), 8'd1);
    chk("beq1_alu_op", 8'(alu_op), 8'd1);
    tick;
    chk("beq1_s0", 8'(state_dbg), 8'd0);
    tick; zero = 1'b0;
    tick; #1;
    chk("beq2_s8", 8'(state_dbg), 8'd8);
    chk("beq2_pc_en", 8'(pc_en), 8'd0);
    tick;
    chk("beq2_s0", 8'(state_dbg), 8'd0);
    // addi
    tick; op = 6'b001000;
    tick;
    chk("addi_s9", 8'(state_dbg), 8'd9);
    chk("addi_s9_srcb", 8'(alu_src_b), 8'd2);
    tick;
    chk("addi_s10", 8'(state_dbg), 8'd10);
    chk("addi_s10_reg_write", 8'(reg_write), 8'd1);
    chk("addi_s10_reg_dst", 8'(reg_dst), 8'd0);
    tick;
    // illegal opcode
    tick; op = 6'b111111; #1;
    chk("ill_s1", 8'(state_dbg), 8'd1);
    chk("ill_pulse", 8'(illegal_op), 8'd1);
    chk("ill_reg_write", 8'(reg_write), 8'd0);
    chk("ill_mem_write", 8'(mem_write), 8'd0);
    chk("ill_pc_en", 8'(pc_en), 8'd0);
    chk("ill_ir_write", 8'(ir_write), 8'd0);
    tick;
    chk("ill_s0", 8'(state_dbg), 8'd0);
    chk("ill_pulse_gone", 8'(illegal_op), 8'd0);
    // jump
    tick; op = 6'b000010;
    tick;
    chk("j_s11", 8'(state_dbg), 8'd11);
    chk("j_pc_src", 8'(pc_src), 8'd2);
    chk("j_pc_en", 8'(pc_en), 8'd1);
    tick;
    chk("j_s0", 8'(state_dbg), 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
